// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, registered
// quotient/remainder with a one-cycle done pulse and a divide-by-zero flag.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic             zero;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_sub;
    logic             fits;

    // Partial remainder is kept below the divisor, so the WIDTH+1-bit difference
    // only goes negative when the shifted value is still smaller than the divisor.
    always_comb begin
        r_shift = {rem, q[WIDTH-1]};
        r_sub   = r_shift - {1'b0, dvsr};
        fits    = r_shift[WIDTH] | ~r_sub[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (divisor == '0) ? FINISH : RUN;
            RUN:     if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= '0;
            rem         <= '0;
            q           <= '0;
            dvsr        <= '0;
            zero        <= 1'b0;
        end else begin
            done <= (state == FINISH);
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        // q doubles as the dividend holder for the divide-by-zero path
                        dvsr  <= divisor;
                        zero  <= (divisor == '0);
                        q     <= dividend;
                        rem   <= '0;
                        count <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    count <= count - CW'(1);
                    q     <= {q[WIDTH-2:0], fits};
                    rem   <= fits ? r_sub[WIDTH-1:0] : r_shift[WIDTH-1:0];
                end
                FINISH: begin
                    quotient    <= zero ? '1 : q;
                    remainder   <= zero ? q : rem;
                    div_by_zero <= zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against a cycle-level
// behavioural model built on integer division.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes a fixed number of edges later with
    // results from plain / and %; requests while one is in flight are dropped.
    int           cyc = 0;
    int           fin_cyc = 0;
    bit           inflight = 0;
    bit           e_busy = 0, e_done = 0, e_dz = 0;
    int           e_q = 0, e_r = 0;
    int           p_q = 0, p_r = 0;
    bit           p_dz = 0;
    bit           sweep = 0, sweep_prev = 0;
    int           last_acc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight = 0; e_busy = 0; e_done = 0; e_dz = 0; e_q = 0; e_r = 0;
        end else begin
            cyc++;
            e_done = 0;
            if (inflight && cyc == fin_cyc) begin
                e_q = p_q; e_r = p_r; e_dz = p_dz; e_done = 1; inflight = 0;
            end else if (!inflight && start) begin
                if (divisor == 0) begin
                    p_q = (1 << W) - 1; p_r = dividend; p_dz = 1; fin_cyc = cyc + 1;
                end else begin
                    p_q = dividend / divisor; p_r = dividend % divisor; p_dz = 0;
                    fin_cyc = cyc + W + 1;
                end
                inflight = 1;
                if (sweep) begin
                    if (sweep_prev) check("accept_spacing", cyc - last_acc, W + 2);
                    sweep_prev = 1;
                    last_acc = cyc;
                end
            end
            e_busy = inflight;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("quotient", quotient, e_q);
            check("remainder", remainder, e_r);
            check("div_by_zero", div_by_zero, e_dz);
        end
    end

    // Drive one request for exactly one edge; returns at the negedge after E0.
    task automatic issue(input int a, input int b);
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after E0 (n=0); checks latency and literal results.
    task automatic wait_done(input string nm, input int eq, input int er, input int edz,
                             input int elat);
        int n = 0;
        bit seen = 0;
        while (n <= 20 && !seen) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        check({nm, "_seen"}, seen, 1);
        check({nm, "_lat"}, n, elat);
        check({nm, "_q"}, quotient, eq);
        check({nm, "_r"}, remainder, er);
        check({nm, "_dz"}, div_by_zero, edz);
        @(negedge clk);
        check({nm, "_done_fall"}, done, 0);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        #13 rst = 1'b0;

        issue(100, 7);
        check("busy_after_e0", busy, 1);
        wait_done("d100_7", 14, 2, 0, 9);
        issue(255, 1);   wait_done("d255_1", 255, 0, 0, 9);
        issue(5, 9);     wait_done("d5_9", 0, 5, 0, 9);
        issue(0, 3);     wait_done("d0_3", 0, 0, 0, 9);
        issue(255, 255); wait_done("d255_255", 1, 0, 0, 9);
        issue(77, 0);    wait_done("d77_0", 255, 77, 1, 1);
        issue(10, 3);    wait_done("d10_3", 3, 1, 0, 9);

        // second request at E3 must be ignored
        issue(200, 13);
        @(negedge clk); @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 15, 5, 0, 6);

        // reset between E4 and E5
        issue(200, 13);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_q", quotient, 0);
        check("mid_rst_r", remainder, 0);
        check("mid_rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int dn = 0;
            repeat (12) begin
                @(negedge clk);
                dn += int'(done);
            end
            check("no_done_after_rst", dn, 0);
        end
        issue(9, 2); wait_done("d9_2", 4, 1, 0, 9);

        // continuous start with random operands
        @(negedge clk);
        sweep = 1;
        start = 1'b1;
        repeat (1000 * (W + 2)) begin
            dividend = W'($urandom_range(0, 255));
            divisor  = W'($urandom_range(1, 255));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        sweep = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
